// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM receive path.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  localparam int TDM_SLOTS = 4;
  localparam int SLOT_W    = 2;

endpackage

// File: rtl/tdm_slot_counter.sv
// 2-bit wrapping slot counter; clear and load-to-1 are steered by the demux FSM.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load1_i,
  input  logic              inc_i,
  output logic [SLOT_W-1:0] slot_o
);

  logic [SLOT_W-1:0] slot_q, slot_d;

  // Priority: clear, then load-to-1 (sync realign), then increment.
  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = SLOT_W'(1);
    end else if (inc_i) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux1_4.sv
// 1:4 time-division demultiplexer: locks to the slot-0 sync marker and
// publishes all four channels together once per complete frame.
module tdm_demux1_4
  import tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              sync,
  output logic [W-1:0]      out0,
  output logic [W-1:0]      out1,
  output logic [W-1:0]      out2,
  output logic [W-1:0]      out3,
  output logic [SLOT_W-1:0] sel,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(TDM_SLOTS - 1);

  tdm_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot;
  logic              cnt_clr, cnt_load1, cnt_inc;
  logic [2:0]        sh_we;
  logic              out_we;
  logic              fv_d, fv_q;
  logic              err_d, err_q;
  logic [W-1:0]      shadow_q [3];
  logic [W-1:0]      out_q    [4];

  tdm_slot_counter u_slot_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .load1_i (cnt_load1),
    .inc_i   (cnt_inc),
    .slot_o  (slot)
  );

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    sh_we     = 3'b000;
    out_we    = 1'b0;
    fv_d      = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (sync) begin
          sh_we[0]  = 1'b1;
          cnt_load1 = 1'b1;
          state_d   = LOCKED;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      LOCKED: begin
        if (sync && slot != '0) begin
          // Early sync: drop the partial frame and realign on this sample.
          err_d     = 1'b1;
          sh_we[0]  = 1'b1;
          cnt_load1 = 1'b1;
        end else if (!sync && slot == '0) begin
          err_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = HUNT;
        end else begin
          cnt_inc = 1'b1;
          if (slot == LAST_SLOT) begin
            out_we = 1'b1;
            fv_d   = 1'b1;
          end else begin
            case (slot)
              2'd0:    sh_we = 3'b001;
              2'd1:    sh_we = 3'b010;
              default: sh_we = 3'b100;
            endcase
          end
        end
      end
      default: begin
        state_d = HUNT;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sh_we[i]) shadow_q[i] <= din;
      end
    end
  end

  // Slot 3 bypasses the shadow bank so the frame publishes one edge after its last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else if (out_we) begin
      out_q[0] <= shadow_q[0];
      out_q[1] <= shadow_q[1];
      out_q[2] <= shadow_q[2];
      out_q[3] <= din;
    end
  end

  assign out0        = out_q[0];
  assign out1        = out_q[1];
  assign out2        = out_q[2];
  assign out3        = out_q[3];
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = (state_q == LOCKED);
  assign sel         = (state_q == LOCKED) ? slot : '0;

endmodule
